dac_cmd_sequencer: RTL and testbench

- Feeds the DAC70004 serial frame shifter: drives DAC_WE/DAC_DATA and consumes its active-low DAC_BUSY.
- Holds one 16-bit shadow code per DAC channel, written by slow control.
- Issues the power-up and reference-enable frames after reset.
- On request, streams one write-and-update frame per modified channel, one frame at a time, with an acknowledge timeout.

---
 rtl/dac70004_pkg.sv | 25 ++
 rtl/dac_cmd_sequencer_if.sv | 22 ++
 rtl/dac_shadow_regs.sv | 44 ++++
 rtl/dac_cmd_sequencer.sv | 89 ++++++++
 tb/tb_dac_cmd_sequencer.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dac70004_pkg.sv
// dac70004_pkg: DAC70004 command codes, fixed init frames, frame builder and sequencer state/source encodings.
package dac70004_pkg;
  localparam logic [3:0] CMD_WRITE_UPDATE = 4'h3;
  localparam logic [3:0] CMD_POWER = 4'h4;
  localparam logic [3:0] CMD_REF = 4'h8;
  localparam logic [31:0] INIT_PWR = {4'h0, CMD_POWER, 4'h0, 16'h000F, 4'h0};
  localparam logic [31:0] INIT_REF = {4'h0, CMD_REF, 4'h0, 16'h0001, 4'h0};
  typedef enum logic [2:0] {
    S_INIT0,
    S_INIT1,
    S_IDLE,
    S_SCAN,
    S_ISSUE,
    S_WAIT_ACK,
    S_WAIT_DONE
  } seq_state_t;
  typedef enum logic [1:0] {
    SRC_PWR,
    SRC_REF,
    SRC_CH
  } frame_src_t;
  function automatic logic [31:0] dac_frame(input logic [3:0] cmd, input logic [3:0] addr, input logic [15:0] code);
    return {4'h0, cmd, addr, code, 4'h0};
  endfunction
endpackage

// File: rtl/dac_cmd_sequencer_if.sv
// dac_cmd_sequencer_if: slow-control and shifter signals; master = environment, slave = sequencer.
interface dac_cmd_sequencer_if;
  logic        CH_WE;
  logic [1:0]  CH_ADDR;
  logic [15:0] CH_DATA;
  logic        UPDATE_REQ;
  logic        ERR_CLR;
  logic        DAC_BUSY;
  logic        DAC_WE;
  logic [31:0] DAC_DATA;
  logic        SEQ_BUSY;
  logic        DONE;
  logic        ERR;
  modport master (
    output CH_WE, CH_ADDR, CH_DATA, UPDATE_REQ, ERR_CLR, DAC_BUSY,
    input  DAC_WE, DAC_DATA, SEQ_BUSY, DONE, ERR
  );
  modport slave (
    input  CH_WE, CH_ADDR, CH_DATA, UPDATE_REQ, ERR_CLR, DAC_BUSY,
    output DAC_WE, DAC_DATA, SEQ_BUSY, DONE, ERR
  );
endinterface

// File: rtl/dac_shadow_regs.sv
// dac_shadow_regs: per-channel shadow codes + dirty bits (we/waddr/wdata write, clr/clr_ch clear, set/set_ch re-mark) with lowest-dirty pick (any_dirty/low_ch/low_code).
module dac_shadow_regs #(
  parameter int CH_NUM = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [1:0]  waddr,
  input  logic [15:0] wdata,
  input  logic        clr,
  input  logic [1:0]  clr_ch,
  input  logic        set,
  input  logic [1:0]  set_ch,
  output logic        any_dirty,
  output logic [1:0]  low_ch,
  output logic [15:0] low_code
);
  logic [15:0] shadow [CH_NUM];
  logic [CH_NUM-1:0] dirty;
  for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
    logic hit;
    assign hit = we && waddr == 2'(i);
    // a write in the same cycle as the clear keeps the channel dirty
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        shadow[i] <= '0;
        dirty[i] <= 1'b0;
      end else begin
        shadow[i] <= hit ? wdata : shadow[i];
        dirty[i] <= hit || (set && set_ch == 2'(i)) || (dirty[i] && !(clr && clr_ch == 2'(i)));
      end
  end
  always_comb begin
    any_dirty = 1'b0;
    low_ch = '0;
    low_code = '0;
    for (int i = CH_NUM - 1; i >= 0; i--)
      if (dirty[i]) begin
        any_dirty = 1'b1;
        low_ch = 2'(i);
        low_code = shadow[i];
      end
  end
endmodule

// File: rtl/dac_cmd_sequencer.sv
// dac_cmd_sequencer: DAC70004 frame sequencer; CLK_50M/RST plus bus (slow-control writes/requests in, DAC_WE/DAC_DATA frames out, DAC_BUSY ack in, SEQ_BUSY/DONE/ERR status out).
module dac_cmd_sequencer
  import dac70004_pkg::*;
#(
  parameter int CH_NUM = 4,
  parameter int ACK_TIMEOUT = 16,
  parameter bit INIT_EN = 1'b1
) (
  input logic CLK_50M,
  input logic RST,
  dac_cmd_sequencer_if.slave bus
);
  seq_state_t state, nxt;
  frame_src_t src;
  logic [1:0] cur_ch;
  logic [7:0] ack_cnt;
  logic any_dirty;
  logic [1:0] low_ch;
  logic [15:0] low_code;
  logic scan_hit, ack_timeout;
  logic dac_we_d, seq_busy_d, done_d;
  logic [31:0] dac_data_d;
  logic dac_we_q, seq_busy_q, done_q, err_q;
  logic [31:0] dac_data_q;
  assign scan_hit = state == S_SCAN && any_dirty;
  assign ack_timeout = state == S_WAIT_ACK && bus.DAC_BUSY && ack_cnt == 8'(ACK_TIMEOUT - 1);
  dac_shadow_regs #(.CH_NUM(CH_NUM)) u_shadow (
    .clk(CLK_50M),
    .rst(RST),
    .we(bus.CH_WE),
    .waddr(bus.CH_ADDR),
    .wdata(bus.CH_DATA),
    .clr(scan_hit),
    .clr_ch(low_ch),
    .set(ack_timeout && src == SRC_CH),
    .set_ch(cur_ch),
    .any_dirty(any_dirty),
    .low_ch(low_ch),
    .low_code(low_code)
  );
  // outputs are registered from next-cycle values so they read 0 while RST is held
  always_ff @(posedge CLK_50M or posedge RST)
    if (RST) begin
      state <= INIT_EN ? S_INIT0 : S_IDLE;
      src <= SRC_PWR;
      cur_ch <= '0;
      ack_cnt <= '0;
      dac_we_q <= 1'b0;
      seq_busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      dac_data_q <= '0;
    end else begin
      state <= nxt;
      src <= state == S_INIT0 ? SRC_PWR : state == S_INIT1 ? SRC_REF : scan_hit ? SRC_CH : src;
      cur_ch <= scan_hit ? low_ch : cur_ch;
      ack_cnt <= state == S_WAIT_ACK ? ack_cnt + 8'd1 : 8'd0;
      dac_we_q <= dac_we_d;
      seq_busy_q <= seq_busy_d;
      done_q <= done_d;
      err_q <= ack_timeout || (err_q && !bus.ERR_CLR);
      dac_data_q <= dac_data_d;
    end
  always_comb begin
    nxt = state;
    case (state)
      S_INIT0, S_INIT1: nxt = S_ISSUE;
      S_IDLE:      nxt = bus.UPDATE_REQ ? S_SCAN : S_IDLE;
      S_SCAN:      nxt = any_dirty ? S_ISSUE : S_IDLE;
      S_ISSUE:     nxt = S_WAIT_ACK;
      S_WAIT_ACK:  nxt = !bus.DAC_BUSY ? S_WAIT_DONE : ack_timeout ? S_IDLE : S_WAIT_ACK;
      S_WAIT_DONE: nxt = !bus.DAC_BUSY ? S_WAIT_DONE : src == SRC_PWR ? S_INIT1 : src == SRC_REF ? S_IDLE : S_SCAN;
      default:     nxt = S_IDLE;
    endcase
  end
  always_comb begin
    dac_we_d = nxt == S_ISSUE;
    seq_busy_d = nxt != S_IDLE;
    done_d = (state == S_SCAN && !any_dirty) || (state == S_WAIT_DONE && bus.DAC_BUSY && src == SRC_REF);
    dac_data_d = state == S_INIT0 ? INIT_PWR :
                 state == S_INIT1 ? INIT_REF :
                 scan_hit ? dac_frame(CMD_WRITE_UPDATE, {2'b00, low_ch}, low_code) : dac_data_q;
  end
  assign bus.DAC_WE = dac_we_q;
  assign bus.DAC_DATA = dac_data_q;
  assign bus.SEQ_BUSY = seq_busy_q;
  assign bus.DONE = done_q;
  assign bus.ERR = err_q;
endmodule

// File: tb/tb_dac_cmd_sequencer.sv
// tb_dac_cmd_sequencer: directed bench with a frame-level reference model checked every cycle.
module tb_dac_cmd_sequencer;
  logic CLK_50M = 1'b0;
  logic RST;
  bit dead;
  int sh_cnt;
  int errors = 0;
  int checks = 0;
  int we_cnt, done_cnt;
  logic [31:0] frames[$];
  dac_cmd_sequencer_if bus ();
  dac_cmd_sequencer dut (
    .CLK_50M(CLK_50M),
    .RST(RST),
    .bus(bus)
  );
  always #10 CLK_50M = ~CLK_50M;
  // shifter: busy low for 66 cycles starting the cycle after DAC_WE, unless dead
  always @(posedge CLK_50M or posedge RST)
    if (RST) sh_cnt <= 0;
    else if (bus.DAC_WE && !dead) sh_cnt <= 66;
    else if (sh_cnt != 0) sh_cnt <= sh_cnt - 1;
  assign bus.DAC_BUSY = sh_cnt == 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  function automatic int lowest(input logic [3:0] d);
    for (int i = 0; i < 4; i++) if (d[i]) return i;
    return -1;
  endfunction
  // reference model: shadows/dirty per channel, frames predicted from the state seen one cycle before DAC_WE
  initial begin
    logic [15:0] m_sh [4];
    logic [15:0] l_sh [4];
    logic [3:0] m_dy, l_dy;
    logic l_wr;
    logic [1:0] l_wa;
    logic [31:0] exp, held;
    bit m_err, pend, hold, seen_low, pch_valid, tmo;
    int m_init, pcnt, ch;
    logic [1:0] pch;
    forever begin
      @(negedge CLK_50M);
      if (RST) begin
        for (int i = 0; i < 4; i++) begin
          m_sh[i] = '0;
          l_sh[i] = '0;
        end
        m_dy = '0;
        l_dy = '0;
        l_wr = 1'b0;
        l_wa = '0;
        m_err = 0;
        pend = 0;
        hold = 0;
        seen_low = 0;
        pch_valid = 0;
        pch = '0;
        m_init = 2;
        pcnt = 0;
      end else begin
        tmo = 0;
        chk("err", bus.ERR, m_err);
        if (bus.DONE) begin
          done_cnt++;
          chk("busy_at_done", bus.SEQ_BUSY, 0);
        end
        if (hold) chk("data_hold", bus.DAC_DATA, held);
        if (bus.DAC_WE) begin
          chk("we_while_pending", pend, 0);
          we_cnt++;
          frames.push_back(bus.DAC_DATA);
          ch = lowest(l_dy);
          if (m_init > 0) begin
            exp = m_init == 2 ? 32'h040000F0 : 32'h08000010;
            m_init--;
            pch_valid = 0;
          end else if (ch < 0) begin
            exp = bus.DAC_DATA;
            errors++;
            checks++;
            $display("FAIL frame: got %h expected no frame", bus.DAC_DATA);
          end else begin
            exp = {4'h0, 4'h3, 4'(ch), l_sh[ch], 4'h0};
            if (!(l_wr && l_wa == 2'(ch))) m_dy[ch] = 1'b0;
            pch = 2'(ch);
            pch_valid = 1;
          end
          chk("frame", bus.DAC_DATA, exp);
          pend = 1;
          pcnt = 0;
          hold = 1;
          held = exp;
          seen_low = 0;
        end else if (pend) begin
          if (!seen_low) begin
            if (!bus.DAC_BUSY) seen_low = 1;
            else begin
              pcnt++;
              if (pcnt == 16) begin
                tmo = 1;
                pend = 0;
                hold = 0;
                m_init = 0;
                if (pch_valid) m_dy[pch] = 1'b1;
              end
            end
          end else if (bus.DAC_BUSY) begin
            pend = 0;
            hold = 0;
          end
        end
        m_err = tmo ? 1'b1 : bus.ERR_CLR ? 1'b0 : m_err;
        l_sh = m_sh;
        l_dy = m_dy;
        l_wr = bus.CH_WE;
        l_wa = bus.CH_ADDR;
        if (bus.CH_WE) begin
          m_sh[bus.CH_ADDR] = bus.CH_DATA;
          m_dy[bus.CH_ADDR] = 1'b1;
        end
      end
    end
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  task automatic step();
    @(posedge CLK_50M);
    #1;
  endtask
  task automatic clear_log();
    we_cnt = 0;
    done_cnt = 0;
    frames.delete();
  endtask
  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    bus.CH_WE = 1'b1;
    bus.CH_ADDR = a;
    bus.CH_DATA = d;
    step();
    bus.CH_WE = 1'b0;
  endtask
  task automatic req();
    bus.UPDATE_REQ = 1'b1;
    step();
    bus.UPDATE_REQ = 1'b0;
  endtask
  task automatic wait_done(input string nm, input int lim);
    int n;
    n = 0;
    do begin
      @(negedge CLK_50M);
      n++;
    end while (!bus.DONE && n < lim);
    chk(nm, bus.DONE, 1);
    step();
  endtask
  task automatic frame_at(input string nm, input int idx, input logic [31:0] exp);
    chk(nm, frames.size() > idx ? frames[idx] : 32'hXXXX_XXXX, exp);
  endtask
  task automatic reset_outputs(input string nm);
    chk({nm, "_we"}, bus.DAC_WE, 0);
    chk({nm, "_data"}, bus.DAC_DATA, 0);
    chk({nm, "_busy"}, bus.SEQ_BUSY, 0);
    chk({nm, "_done"}, bus.DONE, 0);
    chk({nm, "_err"}, bus.ERR, 0);
  endtask
  task automatic idle_req(input string nm);
    clear_log();
    req();
    @(negedge CLK_50M);
    chk({nm, "_done_n1"}, bus.DONE, 0);
    chk({nm, "_busy_n1"}, bus.SEQ_BUSY, 1);
    step();
    @(negedge CLK_50M);
    chk({nm, "_done_n2"}, bus.DONE, 1);
    chk({nm, "_busy_n2"}, bus.SEQ_BUSY, 0);
    step();
    chk({nm, "_we_cnt"}, we_cnt, 0);
  endtask
  initial begin
    int n;
    RST = 1'b1;
    dead = 0;
    bus.CH_WE = 1'b0;
    bus.CH_ADDR = '0;
    bus.CH_DATA = '0;
    bus.UPDATE_REQ = 1'b0;
    bus.ERR_CLR = 1'b0;
    repeat (3) step();
    @(negedge CLK_50M);
    reset_outputs("rst");
    step();
    RST = 1'b0;
    clear_log();
    wait_done("init_done", 400);
    repeat (3) step();
    chk("init_we_cnt", we_cnt, 2);
    frame_at("init_pwr", 0, 32'h040000F0);
    frame_at("init_ref", 1, 32'h08000010);
    chk("init_done_cnt", done_cnt, 1);
    chk("init_idle", bus.SEQ_BUSY, 0);
    wr(2'd2, 16'h8000);
    wr(2'd0, 16'h1234);
    clear_log();
    req();
    @(negedge CLK_50M);
    chk("lat_we_n1", bus.DAC_WE, 0);
    chk("lat_busy_n1", bus.SEQ_BUSY, 1);
    step();
    @(negedge CLK_50M);
    chk("lat_we_n2", bus.DAC_WE, 1);
    step();
    wait_done("upd_done", 400);
    repeat (2) step();
    chk("upd_we_cnt", we_cnt, 2);
    frame_at("upd_ch0", 0, 32'h03012340);
    frame_at("upd_ch2", 1, 32'h03280000);
    chk("upd_done_cnt", done_cnt, 1);
    idle_req("empty");
    dead = 1;
    wr(2'd3, 16'h0BEE);
    clear_log();
    req();
    n = 1;
    while (!bus.ERR && n < 60) begin
      step();
      n++;
    end
    chk("tmo_latency", n, 19);
    chk("tmo_idle", bus.SEQ_BUSY, 0);
    chk("tmo_no_done", done_cnt, 0);
    chk("tmo_we_cnt", we_cnt, 1);
    repeat (5) step();
    chk("err_sticky", bus.ERR, 1);
    bus.ERR_CLR = 1'b1;
    step();
    bus.ERR_CLR = 1'b0;
    chk("err_clr", bus.ERR, 0);
    dead = 0;
    clear_log();
    req();
    wait_done("retry_done", 400);
    repeat (2) step();
    chk("retry_we_cnt", we_cnt, 1);
    frame_at("retry_ch3", 0, 32'h0330BEE0);
    wr(2'd1, 16'h5555);
    clear_log();
    req();
    bus.CH_WE = 1'b1;
    bus.CH_ADDR = 2'd1;
    bus.CH_DATA = 16'hAAAA;
    step();
    bus.CH_WE = 1'b0;
    wait_done("race_done", 400);
    repeat (2) step();
    chk("race_we_cnt", we_cnt, 2);
    frame_at("race_old", 0, 32'h03155550);
    frame_at("race_new", 1, 32'h031AAAA0);
    wr(2'd0, 16'h0FFF);
    clear_log();
    req();
    repeat (10) step();
    chk("mid_data", bus.DAC_DATA, 32'h0300FFF0);
    chk("mid_busy", bus.SEQ_BUSY, 1);
    RST = 1'b1;
    #1;
    reset_outputs("async_rst");
    repeat (2) step();
    RST = 1'b0;
    clear_log();
    wait_done("reinit_done", 400);
    repeat (2) step();
    chk("reinit_we_cnt", we_cnt, 2);
    frame_at("reinit_pwr", 0, 32'h040000F0);
    frame_at("reinit_ref", 1, 32'h08000010);
    idle_req("post_rst");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
